// File: rtl/sinegen_pkg.sv
// -----------------------------------------------------------------------------
// sinegen_pkg
// Shared definitions for the sine ROM sequencer:
//   - default width / latency parameters
//   - FSM state type and state encodings
// Optional feature macro used by the sequencer files: SINEGEN_SWEEP_EN
// -----------------------------------------------------------------------------
package sinegen_pkg;

  localparam int A_WIDTH_DEF   = 8;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int ROM_LAT_DEF   = 1;

  // Sequencer states (IDLE, RUN, DRAIN, DONE), kept as plain constants so the
  // encoding stays visible in legacy register dumps.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sinegen_phase_acc.sv
// -----------------------------------------------------------------------------
// sinegen_phase_acc
// Phase accumulator for the dual-port sine ROM.
//   load        : clear phase, latch step/offset (and sweep) for a new run
//   advance     : emit one sample: addr1 = phase, addr2 = phase + offset,
//                 then phase += step (all modulo 2^A_WIDTH)
//   addr1/addr2 : registered ROM addresses, hold between samples
// Optional feature (macro SINEGEN_SWEEP_EN): cfg_sweep is latched at load and
// added to step every time the phase wraps, saturating at 2^A_WIDTH-1.
// -----------------------------------------------------------------------------
module sinegen_phase_acc #(
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [A_WIDTH-1:0] cfg_step,
  input  logic [A_WIDTH-1:0] cfg_offset,
`ifdef SINEGEN_SWEEP_EN
  input  logic [A_WIDTH-1:0] cfg_sweep,
`endif
  output logic [A_WIDTH-1:0] addr1,
  output logic [A_WIDTH-1:0] addr2
);

  logic [A_WIDTH-1:0] phase_reg;
  logic [A_WIDTH-1:0] step_reg;
  logic [A_WIDTH-1:0] offset_reg;
  logic [A_WIDTH-1:0] addr1_reg;
  logic [A_WIDTH-1:0] addr2_reg;

  // Extra MSB is the wrap (carry out of the period).
  logic [A_WIDTH:0] phase_sum;
  assign phase_sum = {1'b0, phase_reg} + {1'b0, step_reg};

`ifdef SINEGEN_SWEEP_EN
  logic [A_WIDTH-1:0] sweep_reg;
  logic [A_WIDTH:0]   step_sum;
  logic [A_WIDTH-1:0] step_sat;
  assign step_sum = {1'b0, step_reg} + {1'b0, sweep_reg};
  assign step_sat = step_sum[A_WIDTH] ? {A_WIDTH{1'b1}} : step_sum[A_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg  <= '0;
      step_reg   <= '0;
      offset_reg <= '0;
      addr1_reg  <= '0;
      addr2_reg  <= '0;
`ifdef SINEGEN_SWEEP_EN
      sweep_reg  <= '0;
`endif
    end else if (load) begin
      phase_reg  <= '0;
      step_reg   <= cfg_step;
      offset_reg <= cfg_offset;
`ifdef SINEGEN_SWEEP_EN
      sweep_reg  <= cfg_sweep;
`endif
    end else if (advance) begin
      addr1_reg <= phase_reg;
      addr2_reg <= phase_reg + offset_reg;
      phase_reg <= phase_sum[A_WIDTH-1:0];
`ifdef SINEGEN_SWEEP_EN
      // Chirp: the new step takes effect from the next sample onwards.
      if (phase_sum[A_WIDTH]) begin
        step_reg <= step_sat;
      end
`endif
    end
  end

  assign addr1 = addr1_reg;
  assign addr2 = addr2_reg;

endmodule

// File: rtl/sinegen_sequencer.sv
// -----------------------------------------------------------------------------
// sinegen_sequencer
// Sequences the dual-port sine ROM: accepts a run configuration over a
// valid/ready handshake, then emits tick-paced address pairs for both ports.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_valid/cfg_ready           configuration handshake (ready only in IDLE)
//   cfg_step/cfg_offset/cfg_len   frequency step, port-2 offset, length (0 = run
//                                 until stop)
//   cfg_sweep                     step increment per phase wrap (only with
//                                 SINEGEN_SWEEP_EN)
//   stop                          abort request (RUN only)
//   tick                          one sample per tick in RUN
//   addr1/addr2/addr_valid        ROM addresses and their strobe
//   dout_valid                    addr_valid delayed ROM_LAT cycles
//   busy                          RUN or DRAIN
//   done                          one-cycle pulse at end of run / abort
// Optional feature macro: SINEGEN_SWEEP_EN
// -----------------------------------------------------------------------------
module sinegen_sequencer
  import sinegen_pkg::*;
#(
  parameter int A_WIDTH   = A_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int ROM_LAT   = ROM_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [A_WIDTH-1:0]   cfg_step,
  input  logic [A_WIDTH-1:0]   cfg_offset,
  input  logic [CNT_WIDTH-1:0] cfg_len,
`ifdef SINEGEN_SWEEP_EN
  input  logic [A_WIDTH-1:0]   cfg_sweep,
`endif
  input  logic                 stop,
  input  logic                 tick,
  output logic [A_WIDTH-1:0]   addr1,
  output logic [A_WIDTH-1:0]   addr2,
  output logic                 addr_valid,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int DW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [DW-1:0]        DRAIN_LAST = DW'(ROM_LAT - 1);
  localparam logic [DW-1:0]        DRAIN_ONE  = DW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic [CNT_WIDTH-1:0] len_reg;
  logic [DW-1:0]        drain_reg, drain_next;
  logic                 addr_valid_reg, addr_valid_next;

  logic load;
  logic advance;

  assign load    = (state_reg == ST_IDLE) && cfg_valid;
  assign advance = (state_reg == ST_RUN) && tick;

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    drain_next      = drain_reg;
    addr_valid_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_next = ST_RUN;
          count_next = '0;
        end
      end
      ST_RUN: begin
        drain_next = '0;
        if (tick) begin
          addr_valid_next = 1'b1;
          count_next      = count_reg + CNT_ONE;
          // Compare against len-1 before incrementing so len = all-ones
          // never needs a count wider than CNT_WIDTH.
          if ((len_reg != '0) && (count_reg == (len_reg - CNT_ONE))) begin
            state_next = ST_DRAIN;
          end
        end
        if (stop) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = ST_DONE;
        end else begin
          drain_next = drain_reg + DRAIN_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      len_reg        <= '0;
      drain_reg      <= '0;
      addr_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      drain_reg      <= drain_next;
      addr_valid_reg <= addr_valid_next;
      if (load) begin
        len_reg <= cfg_len;
      end
    end
  end

  // Valid pipeline tracking the ROM read latency.
  logic vpipe_reg [ROM_LAT];

  generate
    for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_vpipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) vpipe_reg[gi] <= 1'b0;
          else     vpipe_reg[gi] <= addr_valid_reg;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) vpipe_reg[gi] <= 1'b0;
          else     vpipe_reg[gi] <= vpipe_reg[gi-1];
        end
      end
    end
  endgenerate

  sinegen_phase_acc #(
    .A_WIDTH(A_WIDTH)
  ) u_phase_acc (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .cfg_step  (cfg_step),
    .cfg_offset(cfg_offset),
`ifdef SINEGEN_SWEEP_EN
    .cfg_sweep (cfg_sweep),
`endif
    .addr1     (addr1),
    .addr2     (addr2)
  );

  assign cfg_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done       = (state_reg == ST_DONE);
  assign addr_valid = addr_valid_reg;
  assign dout_valid = vpipe_reg[ROM_LAT-1];

endmodule
